// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU execute-stage units (fmul, fdiv_iter).
//   - IEEE-754 single-precision field widths and constants
//   - fdiv_iter FSM state encoding
//   - fdiv_iter iteration geometry
//
// Build option:
//   FDIV_RADIX4_EN  when defined, two restoring steps are performed per clock.
//                   This gives 13 iterations instead of 25.
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    // The quotient has 1 guard bit and 24 significant bits.
    localparam int QW    = 25;
    localparam int CNT_W = 5;

`ifdef FDIV_RADIX4_EN
    localparam int STEPS = 2;
    localparam int ITER  = 13;
`else
    localparam int STEPS = 1;
    localparam int ITER  = 25;
`endif

    // Counter value held during the final DIV edge.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fdiv_step.sv
// -----------------------------------------------------------------------------
// fdiv_step
// One combinational restoring-division step on the mantissa remainder.
//
// Ports
//   r       in   25  current partial remainder
//   mb      in   24  divisor mantissa, hidden 1 included
//   r_next  out  25  remainder for the next step, already shifted left by 1
//   q_bit   out  1   quotient bit produced by this step
// -----------------------------------------------------------------------------
module fdiv_step (
    input  logic [24:0] r,
    input  logic [23:0] mb,
    output logic [24:0] r_next,
    output logic        q_bit
);

    logic [24:0] mb_ext;
    logic [24:0] diff;
    logic [24:0] sel;

    assign mb_ext = {1'b0, mb};
    assign q_bit  = (r >= mb_ext);
    assign diff   = r - mb_ext;
    assign sel    = q_bit ? diff : r;

    // The invariant r < 2*mb means the shifted value always fits in 25 bits.
    assign r_next = sel << 1;

endmodule

// File: rtl/fdiv_iter.sv
// -----------------------------------------------------------------------------
// fdiv_iter
// Iterative single-precision divider, y = x1 / x2.
//   - Uses hidden-1 mantissas.
//   - Truncates the result; no rounding.
//   - Never produces NaN or denormal outputs.
//   - Inputs with exponent 0 that are not zero are treated as normal numbers.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   in_valid     in   1   operands valid
//   in_ready     out  1   unit accepts operands this cycle
//   x1           in   32  dividend
//   x2           in   32  divisor
//   y_valid      out  1   result valid; held until consumed
//   y_ready      in   1   consumer accepts y
//   y            out  32  quotient
//   dbg_state_o  out  2   current FSM state: 0 = IDLE, 1 = DIV, 2 = DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until that edge. A
// consumer may raise or lower ready freely.
//
// Build option:
//   FDIV_RADIX4_EN  chains two fdiv_step instances, giving 13 DIV edges.
//                   The y value is bit-identical to the default build.
// -----------------------------------------------------------------------------
module fdiv_iter
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [31:0] y,
    output logic [1:0]  dbg_state_o
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sy_q;
    logic               z1_q;
    logic               z2_q;
    logic [EXP_W-1:0]   e1_q;
    logic [EXP_W-1:0]   e2_q;
    logic [23:0]        mb_q;
    logic [24:0]        r_q;
    logic [23:0]        q_q;       // quotient bits collected so far, MSB first
    logic [31:0]        y_q;
    logic               y_valid_q;

    logic               accept;
    logic [24:0]        r_d;
    logic [23:0]        q_d;
    logic [QW-1:0]      quot;
    logic [9:0]         ea;
    logic [MAN_W-1:0]   mant;
    logic [31:0]        y_d;

    logic [24:0]        r1;
    logic               b0;

    assign in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & y_ready);
    assign accept      = in_valid & in_ready;
    assign y           = y_q;
    assign y_valid     = y_valid_q;
    assign dbg_state_o = state_q;

    fdiv_step u_step0 (
        .r      (r_q),
        .mb     (mb_q),
        .r_next (r1),
        .q_bit  (b0)
    );

`ifdef FDIV_RADIX4_EN
    logic [24:0] r2;
    logic        b1;

    fdiv_step u_step1 (
        .r      (r1),
        .mb     (mb_q),
        .r_next (r2),
        .q_bit  (b1)
    );

    assign r_d = r2;
    assign q_d = {q_q[21:0], b0, b1};
`else
    assign r_d = r1;
    assign q_d = {q_q[22:0], b0};
`endif

    // On the final edge, q_q already holds 24 bits and b0 is bit 25.
    // In the radix-4 build, the 26th bit (b1) of that edge is dropped.
    assign quot = {q_q, b0};

    // ea is a 10-bit two's-complement value; bit 9 is the sign.
    assign ea   = {2'b00, e1_q} - {2'b00, e2_q}
                + (quot[QW-1] ? 10'(BIAS) : 10'(BIAS - 1));
    assign mant = quot[QW-1] ? quot[23:1] : quot[22:0];

    always_comb begin
        y_d = {sy_q, ea[7:0], mant};
        if (z2_q) begin
            y_d = {sy_q, EXP_INF, {MAN_W{1'b0}}};
        end else if (z1_q) begin
            y_d = {sy_q, 31'b0};
        end else if (ea[9] || (ea == 10'd0)) begin
            y_d = {sy_q, 31'b0};
        end else if (ea[8:0] >= 9'd255) begin
            y_d = {sy_q, EXP_INF, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sy_q      <= 1'b0;
            z1_q      <= 1'b0;
            z2_q      <= 1'b0;
            e1_q      <= '0;
            e2_q      <= '0;
            mb_q      <= '0;
            r_q       <= '0;
            q_q       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= ST_DONE;
                        y_q       <= y_d;
                        y_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= in_valid ? ST_DIV : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Accept only happens in IDLE or DONE, so it never collides
            // with the DIV updates of r_q, q_q and cnt_q.
            if (accept) begin
                sy_q  <= x1[31] ^ x2[31];
                e1_q  <= x1[30:23];
                e2_q  <= x2[30:23];
                z1_q  <= (x1[30:0] == 31'd0);
                z2_q  <= (x2[30:0] == 31'd0);
                mb_q  <= {1'b1, x2[22:0]};
                r_q   <= {2'b01, x1[22:0]};
                q_q   <= '0;
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
module tb_fdiv_iter;

`ifdef FDIV_RADIX4_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 25;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] y;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];

    fdiv_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x1          (x1),
        .x2          (x2),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .y           (y),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drives one operand pair and waits until it is accepted. On the
    // accept edge, the expected result and the accept cycle are queued.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        while (!done) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1;
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                in_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready stuck at 0 for op %h/%h", a, b);
                    in_valid = 1'b0;
                    done = 1;
                end
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        prev;
        logic [31:0] e;
        int          a;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (y_valid && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got y=%h with expected queue empty", y);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("y_value", y, e);
                        chk("latency", 32'(cyc - a), 32'(LAT));
                    end
                end
                prev = y_valid;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] va[10];
    logic [31:0] vb[10];
    logic [31:0] ve[10];

    initial begin
        va = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h80000000,
               32'h00800000, 32'h7F000000, 32'h00000000, 32'h3F800000, 32'h40400000};
        vb = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000, 32'h3F800000,
               32'h40000000, 32'h3E800000, 32'h00000000, 32'hBF800000, 32'h3F800000};
        ve = '{32'h40400000, 32'h3EAAAAAA, 32'hC0000000, 32'h7F800000, 32'h80000000,
               32'h00000000, 32'h7F800000, 32'h7F800000, 32'hBF800000, 32'h40400000};

        rst      = 1'b1;
        in_valid = 1'b0;
        x1       = '0;
        x2       = '0;
        y_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_y_valid", 32'(y_valid), 32'd0);
        chk("reset_y", y, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_state", 32'(dbg_state), 32'd0);

        // Each directed vector is issued and drained on its own.
        y_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(va[i], vb[i], ve[i]);
            wait_drain("drain_vector");
        end

        // Backpressure: hold the result, then consume and accept on one edge.
        @(negedge clk);
        y_ready = 1'b0;
        send(32'h40C00000, 32'h40000000, 32'h40400000);
        begin
            int n;
            n = 0;
            while (!y_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("bp_y_valid_seen", 32'(y_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_y_stable", y, 32'h40400000);
            chk("bp_y_valid_held", 32'(y_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        y_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h3EAAAAAA);
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        chk("bp_consumed", 32'(y_valid), 32'd0);
        chk("bp_state_div", 32'(dbg_state), 32'd1);
        wait_drain("drain_backpressure");

        // Reset in the middle of a division discards the in-flight result.
        send(32'h7F000000, 32'h3E800000, 32'h7F800000);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_y_valid", 32'(y_valid), 32'd0);
        chk("midrst_y", y, 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        wait_drain("drain_after_reset");
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
